arm_alu: RTL and testbench
==========================

Name:
arm_alu

Overview:
- Registered 32-bit ARM-style integer ALU for the datapath execute stage.
- Computes ADD, SUB, AND or ORR on two operands.
- Produces the result plus N/Z/C/V condition flags for the condition/flag logic.
- Result and flags are registered: one-cycle latency.

Parameters:
- WIDTH, 32, operand and result width in bits; the flag rules below use msb = WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  operation valid; sample the operands and opcode this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- opcode  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- out  output  WIDTH  registered result
- zero  output  1  Z flag: out == 0
- negative  output  1  N flag: out[msb]
- carry  output  1  C flag
- overflow  output  1  V flag
- valid  output  1  high for one cycle when out and the flags hold a newly computed result

Behaviour:
- Reset (sampled on the clk rising edge with reset=1):
  - out=0, zero=0, negative=0, carry=0, overflow=0, valid=0.
  - Reset has priority over en.
  - An operation presented in the same cycle as reset is discarded.
- Latency:
  - Operands sampled on edge k with en=1 appear on the outputs after edge k; valid=1 during that following cycle.
  - Full throughput: one new operation per cycle.
- en=0 on an edge (no reset): out and all flags hold their previous values; valid=0.
- ADD: {cout, sum} = a + b, computed at WIDTH+1 bits.
  - carry = cout.
  - overflow = (a[msb] == b[msb]) and (sum[msb] != a[msb]).
- SUB: result = a + ~b + 1, computed at WIDTH+1 bits.
  - carry = carry-out, ARM convention: 1 means no borrow, i.e. a >= b unsigned.
  - overflow = (a[msb] != b[msb]) and (result[msb] != a[msb]).
- AND: out = a & b.
- ORR: out = a | b.
- For AND and ORR: carry=0 and overflow=0.
- For all opcodes:
  - zero = (result == 0).
  - negative = result[msb].
  - Both are computed from the same-cycle result and registered together with it.
- Wrap-around: arithmetic results are truncated to WIDTH bits; no saturation.
- No X propagation on outputs after reset; opcode is fully decoded, so there is no illegal encoding.
- Implementation:
  - One combinational compute block feeding one output register bank.
  - A shared adder serves ADD and SUB via conditional inversion of b and carry-in.

Test Plan:
- ADD: a=0x0000000A, b=0x00000003, en=1 -> next cycle out=0x0000000D, Z=0, N=0, C=0, V=0, valid=1.
- SUB equal operands: a=b=0x00000003 -> out=0, Z=1, N=0, C=1, V=0. SUB with borrow: a=3, b=5 -> out=0xFFFFFFFE, N=1, C=0, V=0.
- ADD signed overflow: a=0x7FFFFFFF, b=1 -> out=0x80000000, N=1, V=1, C=0. ADD carry-out: a=0xFFFFFFFF, b=1 -> out=0, Z=1, C=1, V=0.
- SUB signed overflow: a=0x80000000, b=1 -> out=0x7FFFFFFF, V=1, C=1, N=0.
- Logic ops: AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000, N=1, C=0, V=0. ORR a=0, b=0 -> out=0, Z=1.
- Control:
  - en held 0 for 3 cycles after an op -> outputs hold, valid=0.
  - Assert reset together with en=1 -> all outputs 0 on the next cycle, the operation is dropped.
  - Back-to-back ops on consecutive cycles -> each result appears exactly one cycle after its inputs.

Source files
------------

// File: rtl/arm_alu.sv
// Registered ARM-style ALU: ADD/SUB/AND/ORR with N/Z/C/V flags, one-cycle latency.
// A single adder is shared by ADD and SUB; SUB feeds ~b with a carry-in of 1.
module arm_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             valid
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_ORR = 2'b11
    } op_t;

    localparam int MSB = WIDTH - 1;

    op_t              op;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign op = op_t'(opcode);

    // After inverting b for SUB, both ADD and SUB overflow reduce to the same
    // rule: like-signed adder inputs giving a differently-signed sum.
    always_comb begin
        is_sub  = (op == OP_SUB);
        b_op    = is_sub ? ~b : b;
        add_sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        res     = add_sum[WIDTH-1:0];
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res   = add_sum[WIDTH-1:0];
                res_c = add_sum[WIDTH];
                res_v = (a[MSB] == b_op[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_AND:  res = a & b;
            OP_ORR:  res = a | b;
            default: res = a & b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                out      <= res;
                zero     <= (res == '0);
                negative <= res[MSB];
                carry    <= res_c;
                overflow <= res_v;
            end
        end
    end

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: vector table, control sequences and random ops,
// with expected results queued at drive time and popped one per clock edge.
module tb_arm_alu;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  opcode;
    logic [31:0] out;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        valid;

    arm_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .opcode(opcode),
        .out(out), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        valid;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    exp_t sb_q[$];
    exp_t held;
    int   errors = 0;
    int   checks = 0;

    // Independent reference: unsigned compare for borrow, wide signed math for V.
    function automatic exp_t model(string name, logic [1:0] op, logic [31:0] x, logic [31:0] y);
        exp_t        e;
        logic [32:0] w;
        longint      sr;
        e.name = name;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            2'b00: begin
                w     = {1'b0, x} + {1'b0, y};
                e.out = w[31:0];
                e.c   = w[32];
                sr    = longint'($signed(x)) + longint'($signed(y));
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'b01: begin
                e.out = x - y;
                e.c   = (x >= y);
                sr    = longint'($signed(x)) - longint'($signed(y));
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'b10:   e.out = x & y;
            default: e.out = x | y;
        endcase
        e.z     = (e.out == 32'd0);
        e.n     = e.out[31];
        e.valid = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input string name, input logic rst, input logic enable,
                                 input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic use_exp, input exp_t given);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        en     = enable;
        opcode = op;
        a      = x;
        b      = y;
        if (rst) begin
            e = '{name, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            held = e;
        end else if (enable) begin
            e = use_exp ? given : model(name, op, x, y);
            e.name = name;
            e.valid = 1'b1;
            held = e;
        end else begin
            e = held;
            e.name = name;
            e.valid = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (out !== e.out || zero !== e.z || negative !== e.n || carry !== e.c ||
            overflow !== e.v || valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL %s: got out=%h z=%b n=%b c=%b v=%b valid=%b, expected out=%h z=%b n=%b c=%b v=%b valid=%b",
                     e.name, out, zero, negative, carry, overflow, valid,
                     e.out, e.z, e.n, e.c, e.v, e.valid);
        end
    endtask

    // Each queued record describes the outputs just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end

    vec_t vecs[8];
    exp_t none;

    initial begin
        vecs[0] = '{"add_basic",   2'b00, 32'h0000000A, 32'h00000003, 32'h0000000D, 0, 0, 0, 0};
        vecs[1] = '{"sub_equal",   2'b01, 32'h00000003, 32'h00000003, 32'h00000000, 1, 0, 1, 0};
        vecs[2] = '{"sub_borrow",  2'b01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 1, 0, 0};
        vecs[3] = '{"add_ovf",     2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1};
        vecs[4] = '{"add_carry",   2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0};
        vecs[5] = '{"sub_ovf",     2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 1};
        vecs[6] = '{"orr_zero",    2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0};
        vecs[7] = '{"and_mask",    2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0};
        none = '{"", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; en = 1'b0; opcode = 2'b00; a = '0; b = '0;
        held = none;

        applyStimulus("reset0", 1, 0, 2'b00, 0, 0, 0, none);
        applyStimulus("reset1", 1, 0, 2'b00, 0, 0, 0, none);

        // Table vectors driven back-to-back to exercise full throughput.
        foreach (vecs[i]) begin
            exp_t e;
            e = '{vecs[i].name, vecs[i].out, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, 1'b1};
            applyStimulus(vecs[i].name, 0, 1, vecs[i].op, vecs[i].a, vecs[i].b, 1, e);
        end

        for (int i = 0; i < 3; i++) applyStimulus("hold", 0, 0, 2'b00, 32'h12345678, 32'h1, 0, none);

        applyStimulus("pre_reset_op", 0, 1, 2'b01, 32'h00000010, 32'h00000001, 0, none);
        applyStimulus("reset_drops_op", 1, 1, 2'b00, 32'hFFFFFFFF, 32'h00000001, 0, none);
        applyStimulus("idle_after_reset", 0, 0, 2'b00, 32'h5, 32'h5, 0, none);
        applyStimulus("post_reset_op", 0, 1, 2'b11, 32'h0F000000, 32'h000000F0, 0, none);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = (i % 4 == 0) ? x : $urandom;
            applyStimulus("random", 0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), x, y, 0, none);
        end

        applyStimulus("drain", 0, 0, 2'b00, 0, 0, 0, none);
        repeat (2) @(negedge clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
